// File: rtl/sprite_dma_responder.sv
`timescale 1ns/1ps
// sprite_dma_responder
//   Shares one single-port work RAM (2^AW x DW, synchronous read) between
//   Z80 CPU bus cycles and the video block's sprite-list DMA fetch.
//   Arbitrates one slot at a time and stalls the other side with a wait.
//
// Ports
//   clk_sys, reset_n          : clock (rising edge), async active-low reset
//   dma_en, dma_addr          : DMA request (held for the transfer) and address
//   dma_wait, dma_data        : high while dma_data is not valid for dma_addr
//   cpu_cs, cpu_rd, cpu_wr    : CPU select and strobes (held until cpu_wait low)
//   cpu_addr, cpu_din         : CPU address / write data
//   cpu_dout, cpu_wait        : registered CPU read data, CPU stall
//   ram_addr, ram_din, ram_we : registered RAM controls
//   ram_dout                  : RAM read data, valid one clock after ram_addr
module sprite_dma_responder #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dma_en,
  input  logic [AW-1:0] dma_addr,
  output logic          dma_wait,
  output logic [DW-1:0] dma_data,
  input  logic          cpu_cs,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_wait,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_LAT,
    ST_RD_CAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_owner;     // owner of the read in flight: 0=CPU, 1=DMA
  logic          r_last;      // last grant: 0=CPU, 1=DMA
  logic          r_dvalid;
  logic [AW-1:0] r_daddr;
  logic          r_cdone;
  logic [AW-1:0] r_caddr;     // address of the CPU access that completed
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;
  logic          r_ram_we;
  logic [DW-1:0] r_dma_data;
  logic [DW-1:0] r_cpu_dout;

  logic          w_cpu_strobe;
  logic          w_creq;
  logic          w_dhit;
  logic          w_dreq;
  logic          w_cdone_drop;
  logic          w_grant;
  logic          w_grant_dma;
  logic          w_grant_wr;
  logic          w_cap_cpu;
  logic          w_cap_dma;

  assign w_cpu_strobe = cpu_rd | cpu_wr;
  assign w_creq       = cpu_cs & w_cpu_strobe & ~r_cdone;
  assign w_dhit       = r_dvalid & (r_daddr == dma_addr);
  assign w_dreq       = dma_en & ~w_dhit;

  // A finished CPU access is forgotten once the bus cycle ends or the CPU
  // moves to a different address without releasing its strobe.
  assign w_cdone_drop = r_cdone & (~cpu_cs | ~w_cpu_strobe | (cpu_addr != r_caddr));

  // ram_addr is held for the whole read, so it doubles as the issued address.
  assign w_cap_cpu = (r_state == ST_RD_CAP) & ~r_owner;
  assign w_cap_dma = (r_state == ST_RD_CAP) &  r_owner;

  assign cpu_wait = w_creq;
  assign dma_wait = w_dreq;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign ram_we   = r_ram_we;
  assign dma_data = r_dma_data;
  assign cpu_dout = r_cpu_dout;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_dma = 1'b0;
    w_grant_wr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_creq | w_dreq) begin
          w_grant = 1'b1;
          // With both requesting, the side that did not win last time wins.
          w_grant_dma = (w_creq & w_dreq) ? ~r_last : w_dreq;
          w_grant_wr  = ~w_grant_dma & cpu_wr;
          if (!w_grant_wr) begin
            w_state_nxt = ST_RD_LAT;
          end
        end
      end
      ST_RD_LAT: w_state_nxt = ST_RD_CAP;
      ST_RD_CAP: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // RAM command registers; ram_we is a single-cycle pulse per write grant.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
      r_owner    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_grant) begin
        r_last     <= w_grant_dma;
        r_owner    <= w_grant_dma;
        r_ram_addr <= w_grant_dma ? dma_addr : cpu_addr;
        if (w_grant_wr) begin
          r_ram_din <= cpu_din;
          r_ram_we  <= 1'b1;
        end
      end
    end
  end

  // CPU completion tracking and read capture.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cdone    <= 1'b0;
      r_caddr    <= '0;
      r_cpu_dout <= '0;
    end else begin
      if (w_cap_cpu) begin
        r_cpu_dout <= ram_dout;
      end
      if (w_cdone_drop) begin
        r_cdone <= 1'b0;
      end else if (w_grant_wr) begin
        r_cdone <= 1'b1;
        r_caddr <= cpu_addr;
      end else if (w_cap_cpu) begin
        // Only complete if the CPU is still asking for the address fetched;
        // otherwise the request stays up and is fetched again.
        r_cdone <= cpu_cs & w_cpu_strobe & (cpu_addr == r_ram_addr);
        r_caddr <= r_ram_addr;
      end
    end
  end

  // DMA data latch and its address tag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dvalid   <= 1'b0;
      r_daddr    <= '0;
      r_dma_data <= '0;
    end else begin
      if (!dma_en) begin
        r_dvalid <= 1'b0;
      end else if (w_grant_wr && w_dhit_wr(r_dvalid, r_daddr, cpu_addr)) begin
        r_dvalid <= 1'b0;
      end else if (w_cap_dma) begin
        r_dvalid   <= 1'b1;
        r_daddr    <= r_ram_addr;
        r_dma_data <= ram_dout;
      end
    end
  end

  // A CPU write to the latched DMA address makes the latch stale.
  function automatic logic w_dhit_wr(input logic valid, input logic [AW-1:0] tag,
                                     input logic [AW-1:0] waddr);
    return valid & (tag == waddr);
  endfunction

endmodule

// File: tb/tb_sprite_dma_responder.sv
`timescale 1ns/1ps
module tb_sprite_dma_responder;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int BUDGET = 32;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          dma_en;
  logic [AW-1:0] dma_addr;
  logic          dma_wait;
  logic [DW-1:0] dma_data;
  logic          cpu_cs, cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  int checks   = 0;
  int failures = 0;
  int we_pulses  = 0;
  int we_consec  = 0;
  logic we_prev  = 1'b0;

  logic [7:0] mem [0:8191];

  sprite_dma_responder #(.AW(AW), .DW(DW)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .dma_en  (dma_en),
    .dma_addr(dma_addr),
    .dma_wait(dma_wait),
    .dma_data(dma_data),
    .cpu_cs  (cpu_cs),
    .cpu_rd  (cpu_rd),
    .cpu_wr  (cpu_wr),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .cpu_dout(cpu_dout),
    .cpu_wait(cpu_wait),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_we  (ram_we),
    .ram_dout(ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous single-port RAM macro: data valid one clock after address.
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk_sys) begin
    if (ram_we) we_pulses++;
    if (ram_we && we_prev) we_consec++;
    we_prev <= ram_we;
  end

  function automatic logic [7:0] pat(input int unsigned a);
    int unsigned v;
    v = (a * 37 + (a >> 7)) ^ 32'h5A;
    return v[7:0];
  endfunction

  // Final RAM contents after the directed writes.
  function automatic logic [7:0] exp_byte(input int unsigned a);
    case (a)
      32'h1500: return 8'hA5;
      32'h0100: return 8'h3C;
      32'h1980: return 8'h22;
      default:  return pat(a);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_dma(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (dma_wait && n < BUDGET);
  endtask

  task automatic wait_cpu(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cpu_wait && n < BUDGET);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nc, p0;
    bit sweep_done;
    sweep_done = 0;
    for (int i = 0; i < 8192; i++) mem[i] = pat(i);
    mem[13'h1500] = 8'hA5;
    mem[13'h1980] = 8'h11;

    reset_n = 1'b0;
    dma_en = 1'b1; dma_addr = 13'h1500;
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
    repeat (2) tick();
    check("rst_dma_wait", dma_wait, 1);
    check("rst_cpu_wait", cpu_wait, 0);
    check("rst_dma_data", dma_data, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_ram_we",   ram_we,   0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din",  ram_din,  0);

    // Uncontended DMA read after reset.
    reset_n = 1'b1;
    wait_dma(nd);
    check("dma_lat", nd, 3);
    check("dma_data_1500", dma_data, 8'hA5);

    // Reset in the middle of a fetch aborts it.
    reset_n = 1'b0;
    #1;
    check("rst_clear_data", dma_data, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_wait", dma_wait, 1);
    tick(); tick();
    check("rst_mid_data", dma_data, 0);
    dma_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("dma_en_low_wait", dma_wait, 0);

    // CPU write then read back.
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h0100; cpu_din = 8'h3C;
    #1;
    check("wr_wait_pre", cpu_wait, 1);
    p0 = we_pulses;
    wait_cpu(nc);
    check("wr_lat", nc, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 13'h0100);
    check("wr_ram_din", ram_din, 8'h3C);
    cpu_cs = 1'b0; cpu_wr = 1'b0;
    tick();
    check("wr_we_drop", ram_we, 0);
    tick();
    check("wr_we_pulses", we_pulses - p0, 1);
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 13'h0100;
    wait_cpu(nc);
    check("rd_lat", nc, 3);
    check("rd_data", cpu_dout, 8'h3C);
    cpu_cs = 1'b0; cpu_rd = 1'b0;
    tick();

    // Contention, last grant was CPU: DMA goes first.
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 13'h0200;
    dma_en = 1'b1; dma_addr = 13'h1504;
    fork
      wait_cpu(nc);
      wait_dma(nd);
    join
    check("arb1_dma_lat", nd, 3);
    check("arb1_cpu_lat", nc, 6);
    check("arb1_dma_data", dma_data, exp_byte(32'h1504));
    check("arb1_cpu_data", cpu_dout, exp_byte(32'h0200));
    cpu_cs = 1'b0; cpu_rd = 1'b0; dma_en = 1'b0;
    tick();
    // Solo DMA read leaves last=DMA, so the CPU wins the next tie.
    dma_en = 1'b1; dma_addr = 13'h1505;
    wait_dma(nd);
    check("solo_dma_lat", nd, 3);
    check("solo_dma_data", dma_data, exp_byte(32'h1505));
    dma_en = 1'b0;
    tick();
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 13'h0201;
    dma_en = 1'b1; dma_addr = 13'h1506;
    fork
      wait_cpu(nc);
      wait_dma(nd);
    join
    check("arb2_cpu_lat", nc, 3);
    check("arb2_dma_lat", nd, 6);
    check("arb2_cpu_data", cpu_dout, exp_byte(32'h0201));
    check("arb2_dma_data", dma_data, exp_byte(32'h1506));
    cpu_cs = 1'b0; cpu_rd = 1'b0; dma_en = 1'b0;
    tick();

    // Coherency: CPU write to the latched DMA address forces a refetch.
    dma_en = 1'b1; dma_addr = 13'h1980;
    wait_dma(nd);
    check("coh_pre_data", dma_data, 8'h11);
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h1980; cpu_din = 8'h22;
    tick();
    check("coh_cpu_wait", cpu_wait, 0);
    check("coh_dma_wait", dma_wait, 1);
    cpu_cs = 1'b0; cpu_wr = 1'b0;
    wait_dma(nd);
    check("coh_refetch_lat", nd, 3);
    check("coh_data", dma_data, 8'h22);
    dma_en = 1'b0;
    #1;
    check("en_low_wait", dma_wait, 0);
    tick();
    check("en_low_hold", dma_data, 8'h22);

    // Address change while the read is in flight.
    dma_en = 1'b1; dma_addr = 13'h1500;
    tick();
    dma_addr = 13'h1501;
    wait_dma(nd);
    check("achg_lat", nd, 5);
    check("achg_data", dma_data, exp_byte(32'h1501));
    dma_en = 1'b0;
    tick();

    // Full sweep with concurrent CPU reads.
    fork
      begin
        for (int unsigned a = 0; a < 8192; a++) begin
          int n;
          dma_addr = a[AW-1:0];
          dma_en = 1'b1;
          wait_dma(n);
          check("sweep", {dma_wait, dma_data}, {1'b0, exp_byte(a)});
          dma_en = 1'b0;
          tick();
        end
        sweep_done = 1;
      end
      begin
        while (!sweep_done) begin
          int n;
          int unsigned ca;
          ca = $urandom_range(0, 8191);
          cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = ca[AW-1:0];
          wait_cpu(n);
          check("cpu_conc_lat", n <= 6, 1);
          check("cpu_conc_data", cpu_dout, exp_byte(ca));
          cpu_cs = 1'b0; cpu_rd = 1'b0;
          tick();
        end
      end
    join

    check("we_consecutive", we_consec, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_dma_responder.md
# sprite_dma_responder

Responder for the video DMA port. Serves the sprite-list fetch issued by the video block through `dma_en`/`dma_addr`/`dma_wait`/`dma_data` from the same single-port 8K×8 work RAM the Z80 uses. It sits between CPU bus decode, the work-RAM macro and the video block. It arbitrates CPU and DMA slots and stretches the losing side with a wait signal.

## Interface
Parameters:
- `AW`, 13, address width (work RAM 2^AW bytes)
- `DW`, 8, data width

Ports:
- `clk_sys` in 1: system clock; all logic on rising edge
- `reset_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `dma_en` in 1: DMA request; held high for the whole transfer
- `dma_addr` in AW: byte address the initiator wants
- `dma_wait` out 1: high = `dma_data` not yet valid for current `dma_addr`
- `dma_data` out DW: registered read data
- `cpu_cs` in 1: CPU selects work RAM
- `cpu_rd`, `cpu_wr` in 1: CPU strobes; held until `cpu_wait` low
- `cpu_addr` in AW; `cpu_din` in DW: CPU address / write data
- `cpu_dout` out DW: registered CPU read data
- `cpu_wait` out 1: CPU stall
- `ram_addr` out AW; `ram_din` out DW; `ram_we` out 1: registered RAM controls
- `ram_dout` in DW: RAM data, valid one clock after `ram_addr` edge

## Operation
- Internal state:
  - `dvalid`, `daddr`: DMA data latch tag.
  - `cdone`: CPU access complete.
  - `last`: last grant, 0=CPU, 1=DMA.
  - FSM `IDLE`, `RD_LAT`, `RD_CAP`, plus `owner` bit.
- Requests:
  - `creq = cpu_cs & (cpu_rd|cpu_wr) & ~cdone`
  - `dreq = dma_en & ~(dvalid & daddr==dma_addr)`
- Waits, combinational:
  - `cpu_wait = creq`
  - `dma_wait = dreq`
- `cdone` clears when `cpu_cs` or both strobes drop, or `cpu_addr` changes while strobed (access restarts).
- IDLE grant:
  - Only one requester: that requester wins.
  - Both requesting: the side ≠ `last` wins (strict alternation); `last` updates on every grant.
- CPU write grant:
  - Register `ram_addr=cpu_addr`, `ram_din=cpu_din`, `ram_we=1` for one cycle.
  - Set `cdone` the same edge; stay in IDLE.
  - If `dvalid & daddr==cpu_addr`, clear `dvalid` (coherency).
- Read grant, CPU or DMA:
  - Register `ram_addr`, `ram_we=0`; go to RD_LAT, then RD_CAP.
  - In RD_CAP, latch `ram_dout` into `cpu_dout` (set `cdone`) or into `dma_data` (set `dvalid`, `daddr` = address issued); return to IDLE.
- DMA read whose `dma_addr` changed during flight: the captured tag mismatches, so `dreq` stays high and a new fetch starts. No stale data is ever shown with `dma_wait` low.
- `dma_en` low: `dvalid` cleared, `dma_wait` 0. `dma_data` holds its last value.
- CPU write during a DMA read in flight:
  - The write waits for IDLE.
  - If it hits the address just captured, the invalidate takes priority over nothing; `dvalid` is already set, so it is cleared in the write-grant cycle.
- `ram_we` is never high two consecutive cycles; it is always 0 outside a write grant.

## Timing
- Reset (async assert, sync release): FSM IDLE; `dvalid=cdone=last=0`; `ram_we=0`; `ram_addr=0`; `ram_din=0`; `dma_data=0`; `cpu_dout=0`. `dma_wait` follows `dma_en`, `cpu_wait` follows the strobes.
- Reset mid-read aborts the access; no latch is updated.
- Read latency, uncontended: request seen in IDLE at edge E0 → `ram_addr` E0 → RAM data E1 → latch E2. Wait is low in the cycle after E2: 3 cycles of wait.
- Write latency, uncontended: wait is high for 1 cycle; RAM commits at E1.
- Contended worst case: one extra 3-cycle read slot before the loser is granted.
- Throughput: one read per 3 cycles, one write per cycle.

## Test plan
- Reset with RAM[0x1500]=0xA5, `dma_en=1`, `dma_addr=0x1500` → `dma_wait` high 3 cycles, then low with `dma_data=0xA5`. Assert `reset_n` low mid-fetch → `dma_data` stays 0, `dma_wait` high.
- CPU write 0x3C to 0x0100 → `cpu_wait` high 1 cycle, `ram_we` one pulse. CPU read 0x0100 → `cpu_dout=0x3C` after 3 wait cycles.
- Simultaneous CPU read 0x0200 and DMA 0x1504 with `last=0` → DMA served first (3 cycles), then CPU. Repeat both → alternate order.
- DMA holds 0x1980 (valid, data 0x11); CPU writes 0x22 to 0x1980 → `dma_wait` rises, refetch, `dma_data=0x22`.
- Change `dma_addr` 0x1500→0x1501 during RD_LAT → first capture ignored, `dma_wait` stays high until RAM[0x1501] is latched.
- Full sweep 0x0000→0x1FFF, initiator style (addr, 1 idle, hold) → every captured byte matches RAM. The CPU issues reads concurrently and each completes within 6 cycles.
